// File: rtl/AESDefinitions.sv
// Shared AES definitions: byte/key types, forward S-box, round constants and
// the word-level helpers used by the key schedule logic.
package AESDefinitions;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] roundKey_t;

  // Control states of the inverse key schedule walker.
  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } ks_state_t;

  // Forward AES S-box, indexed by the input byte value.
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants; entry 0 is never used by a 128-bit schedule.
  localparam byte_t RCON [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rotate a word left by one byte (byte 0 is the MSB).
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Apply the forward S-box to every byte of a word.
  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/inverse_key_step.sv
// Combinational step of the inverse AES-128 key schedule: given round key r,
// produce round key r-1.
module inverse_key_step
  import AESDefinitions::*;
(
  input  roundKey_t   key_in,
  input  logic [3:0]  round,
  output roundKey_t   key_out
);

  word_t c0, c1, c2, c3;
  word_t p0, p1, p2, p3;
  byte_t rcon;

  assign c0 = key_in[127:96];
  assign c1 = key_in[95:64];
  assign c2 = key_in[63:32];
  assign c3 = key_in[31:0];

  // Undo the running XOR chain of the forward schedule column by column.
  assign p3 = c3 ^ c2;
  assign p2 = c2 ^ c1;
  assign p1 = c1 ^ c0;

  // Rounds beyond the constant table never occur for a legal walk; force 0.
  assign rcon = (round <= 4'd10) ? RCON[round] : 8'h00;

  // Column 0 needs the recovered column 3 of the previous key.
  assign p0 = c0 ^ sub_word(rot_word(p3)) ^ {rcon, 24'h000000};

  assign key_out = {p0, p1, p2, p3};

endmodule

// File: rtl/inverse_key_schedule.sv
// Inverse AES-128 key schedule: accepts the final round key and streams the
// round keys from NUM_ROUNDS down to 0, one per accepted output handshake.
module inverse_key_schedule
  import AESDefinitions::*;
#(
  parameter int KEY_SIZE   = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  roundKey_t   last_key,
  output logic        out_valid,
  input  logic        out_ready,
  output roundKey_t   round_key,
  output logic [3:0]  round_index,
  output logic        out_last
);

  // Only the 128-bit schedule with up to ten rounds is supported.
  generate
    if (KEY_SIZE != 128) begin : g_bad_key_size
      $error("inverse_key_schedule: KEY_SIZE must be 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
      $error("inverse_key_schedule: NUM_ROUNDS must be in 1..10");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_t   state_reg;
  roundKey_t   key_reg;
  logic [3:0]  index_reg;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic        out_last_reg;
  roundKey_t   key_next;
  logic        out_fire;

  inverse_key_step u_step (
    .key_in  (key_reg),
    .round   (index_reg),
    .key_out (key_next)
  );

  assign out_fire = out_valid_reg & out_ready;

  // Control FSM plus key/index registers; reset wins over any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      key_reg       <= '0;
      index_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg     <= GEN;
            key_reg       <= last_key;
            index_reg     <= LAST_ROUND;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            out_last_reg  <= (LAST_ROUND == 4'd0);
          end
        end
        GEN: begin
          if (out_fire) begin
            if (index_reg == 4'd0) begin
              // Final key consumed; accept a new key only from next cycle.
              state_reg     <= IDLE;
              in_ready_reg  <= 1'b1;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
            end else begin
              key_reg      <= key_next;
              index_reg    <= index_reg - 4'd1;
              out_last_reg <= (index_reg == 4'd1);
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_last    = out_last_reg;
  assign round_key   = key_reg;
  assign round_index = index_reg;

endmodule

// File: tb/tb_inverse_key_schedule.sv
// Directed bench for inverse_key_schedule with an independent forward
// AES-128 key expansion model (S-box derived from GF(2^8) arithmetic).
module tb_inverse_key_schedule;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] last_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] round_key;
  logic [3:0]   round_index;
  logic         out_last;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0]   tb_sbox [256];
  logic [7:0]   tb_rcon [11];
  logic [127:0] model_keys [11];

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] OTHER_K  = 128'h00112233445566778899aabbccddeeff;

  inverse_key_schedule #(
    .KEY_SIZE   (128),
    .NUM_ROUNDS (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .last_key    (last_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .round_key   (round_key),
    .round_index (round_index),
    .out_last    (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] r;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      tb_sbox[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    tb_rcon[0] = 8'h00;
    r = 8'h01;
    for (int i = 1; i < 11; i++) begin
      tb_rcon[i] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  function automatic logic [31:0] model_t(input logic [31:0] w, input int rnd);
    logic [31:0] rw;
    rw = {w[23:0], w[31:24]};
    return {tb_sbox[rw[31:24]] ^ tb_rcon[rnd], tb_sbox[rw[23:16]],
            tb_sbox[rw[15:8]], tb_sbox[rw[7:0]]};
  endfunction

  // Forward expansion of a round-0 key into model_keys[0..10].
  task automatic fwd_expand(input logic [127:0] k0);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k0;
    model_keys[0] = k0;
    for (int r = 1; r <= 10; r++) begin
      w0 = w0 ^ model_t(w3, r);
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      model_keys[r] = {w0, w1, w2, w3};
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    int waited;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check_count++;
      $display("FAIL load_wait: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1;
    last_key = k;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    check_count++;
    if ({out_valid, out_last, round_index, round_key, in_ready} !== {1'b0, 1'b0, 4'd0, 128'd0, 1'b1})
      $display("FAIL reset_state: valid=%b last=%b idx=%0d key=%h in_ready=%b required 0/0/0/0/1",
               out_valid, out_last, round_index, round_key, in_ready);
    else pass_count++;
    reset = 1'b0;
    step();
    check_count++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else pass_count++;
    $display("test_reset done");
  endtask

  task automatic test_full_throughput();
    fwd_expand(FIPS_K0);
    out_ready = 1'b1;
    load_key(FIPS_K10);
    for (int e = 10; e >= 0; e--) begin
      check_count++;
      if ({out_valid, round_index, out_last, round_key} !== {1'b1, 4'(e), 1'(e == 0), model_keys[e]})
        $display("FAIL full_seq[%0d]: valid=%b idx=%0d last=%b key=%h required 1/%0d/%0b/%h",
                 e, out_valid, round_index, out_last, round_key, e, e == 0, model_keys[e]);
      else pass_count++;
      if (e == 10 || e == 9 || e == 1 || e == 0) begin
        check_count++;
        if (round_key !== (e == 10 ? FIPS_K10 : e == 9 ? FIPS_K9 : e == 1 ? FIPS_K1 : FIPS_K0))
          $display("FAIL fips_vector[%0d]: key=%h", e, round_key);
        else pass_count++;
      end
      step();
    end
    check_count++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL full_end: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else pass_count++;
    $display("test_full_throughput done");
  endtask

  task automatic test_stall();
    int e;
    int cycles;
    logic prev_stall;
    logic [127:0] prev_key;
    logic [3:0] prev_idx;
    fwd_expand(FIPS_K0);
    out_ready = 1'b0;
    load_key(FIPS_K10);
    e = 10;
    cycles = 0;
    prev_stall = 1'b0;
    prev_key = '0;
    prev_idx = '0;
    while (e >= 0 && cycles < 300) begin
      check_count++;
      if ({out_valid, round_index, out_last, round_key} !== {1'b1, 4'(e), 1'(e == 0), model_keys[e]})
        $display("FAIL stall_seq[%0d]: valid=%b idx=%0d last=%b key=%h required 1/%0d/%0b/%h",
                 e, out_valid, round_index, out_last, round_key, e, e == 0, model_keys[e]);
      else pass_count++;
      if (prev_stall) begin
        check_count++;
        if ({round_index, round_key} !== {prev_idx, prev_key})
          $display("FAIL stall_hold: idx=%0d key=%h required %0d/%h", round_index, round_key, prev_idx, prev_key);
        else pass_count++;
      end
      out_ready = 1'($urandom_range(0, 1));
      prev_stall = ~out_ready;
      prev_key = round_key;
      prev_idx = round_index;
      if (out_ready) e--;
      step();
      cycles++;
    end
    if (e >= 0) begin
      check_count++;
      $display("FAIL stall_timeout: index %0d never transferred", e);
    end
    out_ready = 1'b1;
    check_count++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL stall_end: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else pass_count++;
    $display("test_stall done");
  endtask

  task automatic test_ignore_new_key();
    fwd_expand(FIPS_K0);
    out_ready = 1'b1;
    load_key(FIPS_K10);
    in_valid = 1'b1;
    last_key = OTHER_K;
    for (int e = 10; e >= 0; e--) begin
      check_count++;
      if ({out_valid, in_ready, round_index, round_key} !== {1'b1, 1'b0, 4'(e), model_keys[e]})
        $display("FAIL ignore_seq[%0d]: valid=%b in_ready=%b idx=%0d key=%h required 1/0/%0d/%h",
                 e, out_valid, in_ready, round_index, round_key, e, model_keys[e]);
      else pass_count++;
      step();
    end
    check_count++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL ignore_gap: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else pass_count++;
    step();
    in_valid = 1'b0;
    check_count++;
    if ({out_valid, round_index, round_key} !== {1'b1, 4'd10, OTHER_K})
      $display("FAIL ignore_reload: valid=%b idx=%0d key=%h required 1/10/%h",
               out_valid, round_index, round_key, OTHER_K);
    else pass_count++;
    repeat (11) step();
    check_count++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL ignore_drain: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else pass_count++;
    $display("test_ignore_new_key done");
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b1;
    load_key(FIPS_K10);
    n = 0;
    while (round_index !== 4'd5 && n < 20) begin
      step();
      n++;
    end
    check_count++;
    if ({out_valid, round_index} !== {1'b1, 4'd5})
      $display("FAIL midreset_reach: valid=%b idx=%0d required 1/5", out_valid, round_index);
    else pass_count++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_count++;
    if ({out_valid, round_index, in_ready, out_last, round_key} !== {1'b0, 4'd0, 1'b1, 1'b0, 128'd0})
      $display("FAIL midreset_state: valid=%b idx=%0d in_ready=%b last=%b key=%h required 0/0/1/0/0",
               out_valid, round_index, in_ready, out_last, round_key);
    else pass_count++;
    for (int i = 0; i < 3; i++) begin
      step();
      check_count++;
      if (out_valid !== 1'b0)
        $display("FAIL midreset_quiet[%0d]: out_valid=%b required 0", i, out_valid);
      else pass_count++;
    end
    load_key(FIPS_K10);
    check_count++;
    if ({out_valid, round_index, round_key} !== {1'b1, 4'd10, FIPS_K10})
      $display("FAIL midreset_restart: valid=%b idx=%0d key=%h required 1/10/%h",
               out_valid, round_index, round_key, FIPS_K10);
    else pass_count++;
    repeat (11) step();
    $display("test_reset_mid done");
  endtask

  task automatic test_zero_key();
    logic [127:0] k0;
    out_ready = 1'b1;
    load_key(128'd0);
    k0 = '0;
    for (int e = 10; e >= 0; e--) begin
      if (e == 0) begin
        k0 = round_key;
        check_count++;
        if ({out_valid, round_index, out_last} !== {1'b1, 4'd0, 1'b1})
          $display("FAIL zero_last: valid=%b idx=%0d last=%b required 1/0/1", out_valid, round_index, out_last);
        else pass_count++;
      end
      step();
    end
    fwd_expand(k0);
    check_count++;
    if (model_keys[10] !== 128'd0)
      $display("FAIL zero_roundtrip: forward(%h) round10=%h required 0", k0, model_keys[10]);
    else pass_count++;
    $display("test_zero_key done");
  endtask

  task automatic test_random_keys();
    logic [127:0] k0;
    int errs;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      fwd_expand(k0);
      load_key(model_keys[10]);
      errs = 0;
      for (int e = 10; e >= 0; e--) begin
        check_count++;
        if ({out_valid, round_index, out_last, round_key} !== {1'b1, 4'(e), 1'(e == 0), model_keys[e]}) begin
          errs++;
          if (errs == 1)
            $display("FAIL random[%0d][%0d]: valid=%b idx=%0d key=%h required 1/%0d/%h",
                     n, e, out_valid, round_index, round_key, e, model_keys[e]);
        end else pass_count++;
        step();
      end
    end
    $display("test_random_keys done");
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    last_key = '0;
    build_tables();
    test_reset();
    test_full_throughput();
    test_stall();
    test_ignore_new_key();
    test_reset_mid();
    test_zero_key();
    test_random_keys();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
